// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration helpers for the reset sequencer.
// Holds the FSM state encoding, counter sizing and parameter legality check.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

    // Wide enough to hold the larger of the hold and spacing terminal counts.
    function automatic int cnt_width(input int min_assert, input int step_cycles);
        int longest;
        longest = (min_assert > step_cycles) ? min_assert : step_cycles;
        return $clog2(longest + 1);
    endfunction

    function automatic bit params_legal(input int num_ch, input int sync_stages,
                                        input int min_assert, input int step_cycles);
        return (num_ch >= 1) && (sync_stages >= 2) && (min_assert >= 1) && (step_cycles >= 1);
    endfunction

endpackage

// File: rtl/rst_seq_gen_stretch.sv
// Per-channel software reset stretcher: holds one channel low MIN_ASSERT cycles after its last request.
// Latency: output drops on the edge sampling sw_rst, releases MIN_ASSERT edges after the last request.
// Backpressure: none; requests on an unreleased channel are ignored, a global clear wins over everything.
module rst_stretch #(
    parameter int MIN_ASSERT = 8,
    parameter int CNT_W      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic rel,
    input  logic rel_nxt,
    input  logic sw_rst,
    output logic rst_n
);

    logic [CNT_W-1:0] cnt_q;
    logic             hold_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q  <= '0;
            hold_q <= 1'b0;
            rst_n  <= 1'b0;
        end else if (rel && sw_rst) begin
            // A repeat request while already held restarts the full hold.
            cnt_q  <= CNT_W'(MIN_ASSERT - 1);
            hold_q <= 1'b1;
            rst_n  <= 1'b0;
        end else if (hold_q) begin
            if (cnt_q == '0) begin
                hold_q <= 1'b0;
                rst_n  <= rel_nxt;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
                rst_n <= 1'b0;
            end
        end else begin
            rst_n <= rel_nxt;
        end
    end

endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: sync ext request, hold all channels MIN_ASSERT cycles, release ascending every STEP_CYCLES (scan bypass under RST_SEQ_TEST_EN).
// Latency: ext_rst_n rise -> ch0 release after SYNC_STAGES+MIN_ASSERT edges; ext_rst_n fall -> all low within SYNC_STAGES+1 edges.
// Backpressure: none; free-running, software resets only stretch already-released channels.
module rst_seq_gen #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_ASSERT  = 8,
    parameter int STEP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_rst_n,
    input  logic [NUM_CH-1:0] sw_rst,
    input  logic              test_shift,
    output logic [NUM_CH-1:0] rst_out_n,
    output logic              seq_busy,
    output logic              seq_done
);
    import rst_seq_pkg::*;

    localparam int CNT_W = cnt_width(MIN_ASSERT, STEP_CYCLES);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (!params_legal(NUM_CH, SYNC_STAGES, MIN_ASSERT, STEP_CYCLES)) begin : g_param_check
        $error("rst_seq_gen: illegal parameter combination");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ext_sync_n;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], ext_rst_n};
    end
    assign ext_sync_n = sync_q[SYNC_STAGES-1];

    seq_state_t        state_q, state_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic [IDX_W-1:0]  idx_q, idx_nxt, idx_inc;
    logic [NUM_CH-1:0] rel_q, rel_nxt;
    logic              clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ASSERT;
            cnt_q    <= '0;
            idx_q    <= '0;
            rel_q    <= '0;
            seq_busy <= 1'b1;
            seq_done <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            idx_q    <= idx_nxt;
            rel_q    <= rel_nxt;
            seq_busy <= (state_nxt != RUN);
            seq_done <= (state_nxt == RUN);
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        idx_nxt   = idx_q;
        rel_nxt   = rel_q;
        clr       = 1'b0;
        idx_inc   = idx_q + IDX_W'(1);
        if (!ext_sync_n) begin
            // External request overrides every state, including mid-release.
            state_nxt = ASSERT;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            rel_nxt   = '0;
            clr       = 1'b1;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (cnt_q == CNT_W'(MIN_ASSERT - 1)) begin
                        cnt_nxt    = '0;
                        idx_nxt    = '0;
                        rel_nxt    = '0;
                        rel_nxt[0] = 1'b1;
                        state_nxt  = (NUM_CH == 1) ? RUN : RELEASE;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
                        cnt_nxt          = '0;
                        idx_nxt          = idx_inc;
                        rel_nxt[idx_inc] = 1'b1;
                        if (idx_inc == IDX_W'(NUM_CH - 1)) state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    logic [NUM_CH-1:0] rst_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rst_stretch #(
            .MIN_ASSERT(MIN_ASSERT),
            .CNT_W     (CNT_W)
        ) u_stretch (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .rel    (rel_q[i]),
            .rel_nxt(rel_nxt[i]),
            .sw_rst (sw_rst[i]),
            .rst_n  (rst_q[i])
        );
    end

`ifdef RST_SEQ_TEST_EN
    assign rst_out_n = rst_q | {NUM_CH{test_shift}};
`else
    logic unused_test_shift;
    assign unused_test_shift = test_shift;
    assign rst_out_n         = rst_q;
`endif

endmodule

// File: doc/rst_seq_gen.md
# rst_seq_gen

Parametrised reset sequencer generating NUM_CH active-low domain resets from one external asynchronous reset request plus per-channel software resets. Synchronises the external request, enforces a minimum assertion width, and releases channels in ascending order with a fixed spacing. Supports a scan bypass that forces every output released. Sits at the top of each clock domain, feeding downstream subsystem resets.

## Interface
- NUM_CH, 4: number of reset output channels (≥1)
- SYNC_STAGES, 2: synchroniser depth on ext_rst_n (≥2)
- MIN_ASSERT, 8: minimum cycles any output is held asserted (≥1)
- STEP_CYCLES, 16: cycles between successive channel releases (≥1)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high master reset
- ext_rst_n  in  1  asynchronous external reset request, active low
- sw_rst  in  NUM_CH  per-channel software reset request, active high, sampled each cycle
- test_shift  in  1  scan-shift bypass
- rst_out_n  out  NUM_CH  registered domain resets, active low
- seq_busy  out  1  high in ASSERT or RELEASE
- seq_done  out  1  high in RUN

## Operation
- Sync chain: ext_rst_n passes through SYNC_STAGES flops → ext_sync_n. On rst, all chain flops load 0.
- FSM states: ASSERT, RELEASE, RUN.
- Global override: ext_sync_n==0 in any state → next state ASSERT, cnt←0, all rst_out_n←0, pending software stretches cleared.
- ASSERT: all outputs 0. With ext_sync_n==1, cnt increments; at cnt==MIN_ASSERT-1 → RELEASE, idx←0, cnt←0, rst_out_n[0]←1 on that edge.
- RELEASE: cnt increments; at cnt==STEP_CYCLES-1, idx+1 released, cnt←0. Edge releasing channel NUM_CH-1 also enters RUN. NUM_CH==1: ASSERT goes directly to RUN.
- Software reset: for any channel already released (RELEASE or RUN), sw_rst[i]==1 at an edge → rst_out_n[i]←0 on that edge and stretch counter i←MIN_ASSERT-1; counter decrements each cycle with sw_rst[i]==0; channel released on the edge where counter is 0. Re-request while held restarts the count. sw_rst for unreleased channels ignored.
- Software resets do not change FSM state; seq_done stays high in RUN.
- Counter width: $clog2(max(MIN_ASSERT, STEP_CYCLES)+1); no wrap, counters saturate at terminal value.

## Timing
- Reset values (rst high at edge): state ASSERT, cnt 0, idx 0, rst_out_n all 0, seq_busy 1, seq_done 0, stretch counters 0.
- ext_rst_n rise → ext_sync_n rise after SYNC_STAGES edges; channel 0 released MIN_ASSERT edges later; channel k released k·STEP_CYCLES edges after channel 0.
- ext_rst_n fall → all outputs 0 within SYNC_STAGES+1 edges, including mid-RELEASE (partially released channels re-asserted, sequence restarts from channel 0).
- sw_rst[i] → rst_out_n[i] low 1 edge later; held exactly MIN_ASSERT cycles after last request.
- Simultaneous ext_sync_n==0 and sw_rst: global override wins.
- seq_busy/seq_done registered, consistent with state on same edge.

## Configuration
- RST_SEQ_TEST_EN defined: rst_out_n = registered value OR {NUM_CH{test_shift}} (combinational bypass); internal state unaffected by test_shift.
- Not defined: test_shift port present but ignored; rst_out_n purely registered.

## Structure
- Package rst_seq_pkg: state enum typedef (ASSERT, RELEASE, RUN), counter-width function, parameter legality checks.
- Sub-module rst_stretch: one per channel, holds sw stretch counter and channel hold flag; instantiated NUM_CH times via generate.

## Test plan
- NUM_CH=4, SYNC_STAGES=2, MIN_ASSERT=8, STEP_CYCLES=16; rst 1 cycle then ext_rst_n=1 → ch0 released 10 edges after rst drop, ch1/2/3 at +16/+32/+48; seq_done high with ch3.
- ext_rst_n pulsed low 1 cycle during RELEASE after ch1 released → all outputs 0 within 3 edges, full sequence repeats from ch0.
- In RUN, sw_rst[2]=1 one cycle → rst_out_n[2] low next edge for 8 cycles; others stay 1; seq_done stays 1.
- sw_rst[1] re-pulsed at cycle 5 of its hold → held 8 cycles after second pulse (13 total).
- RST_SEQ_TEST_EN defined, test_shift=1 during ASSERT → rst_out_n=4'hF; test_shift=0 → 4'h0 same cycle; without macro, test_shift=1 has no effect.
- sw_rst[3]=1 while ch3 unreleased in RELEASE → ignored, ch3 released on schedule.
